// File: rtl/gcn_layer_scheduler.sv
// Per-layer sequencer for the GCN datapath: clear/start the transformation FSM, then the
// combination FSM, flipping the ping-pong buffer between layers, with watchdog and abort.
module gcn_layer_scheduler #(
    parameter int unsigned NUM_LAYERS     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned LAYER_W        = ($clog2(NUM_LAYERS) > 0) ? $clog2(NUM_LAYERS) : 1,
    parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               go_i,
    input  logic               abort_i,
    input  logic               trans_done_i,
    input  logic               comb_done_i,
    output logic               trans_clear_o,
    output logic               trans_start_o,
    output logic               comb_clear_o,
    output logic               comb_start_o,
    output logic               buf_sel_o,
    output logic [LAYER_W-1:0] layer_idx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o
);

    typedef enum logic [3:0] {
        StIdle,
        StClrT,
        StStartT,
        StWaitT,
        StClrC,
        StStartC,
        StWaitC,
        StNext,
        StDone,
        StError,
        StAbort
    } state_e;

    localparam logic [LAYER_W-1:0] LastLayer = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [TO_W-1:0]    LastWd    = TO_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [TO_W-1:0]    wd_q, wd_d;
    logic               trans_clear_q, trans_start_q, comb_clear_q, comb_start_q;
    logic               busy_q, done_q, error_q;

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        wd_d    = wd_q;
        // Abort has priority over every other condition outside IDLE/ABORT.
        if (abort_i && (state_q != StIdle) && (state_q != StAbort)) begin
            state_d = StAbort;
        end else begin
            case (state_q)
                StIdle: begin
                    if (go_i) begin
                        state_d = StClrT;
                        layer_d = '0;
                    end
                end
                StClrT:   state_d = StStartT;
                StStartT: begin
                    state_d = StWaitT;
                    wd_d    = '0;
                end
                StWaitT: begin
                    if (trans_done_i) begin
                        state_d = StClrC;
                    end else if (wd_q == LastWd) begin
                        state_d = StError;
                    end else begin
                        wd_d = wd_q + TO_W'(1);
                    end
                end
                StClrC:   state_d = StStartC;
                StStartC: begin
                    state_d = StWaitC;
                    wd_d    = '0;
                end
                StWaitC: begin
                    if (comb_done_i) begin
                        state_d = StNext;
                    end else if (wd_q == LastWd) begin
                        state_d = StError;
                    end else begin
                        wd_d = wd_q + TO_W'(1);
                    end
                end
                StNext: begin
                    if (layer_q == LastLayer) begin
                        state_d = StDone;
                    end else begin
                        layer_d = layer_q + LAYER_W'(1);
                        state_d = StClrT;
                    end
                end
                StDone, StError: begin
                    if (go_i) begin
                        state_d = StClrT;
                        layer_d = '0;
                    end
                end
                StAbort: begin
                    state_d = StIdle;
                    layer_d = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            layer_q       <= '0;
            wd_q          <= '0;
            trans_clear_q <= 1'b0;
            trans_start_q <= 1'b0;
            comb_clear_q  <= 1'b0;
            comb_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            layer_q       <= layer_d;
            wd_q          <= wd_d;
            trans_clear_q <= (state_d == StClrT) || (state_d == StAbort);
            trans_start_q <= (state_d == StStartT);
            comb_clear_q  <= (state_d == StClrC) || (state_d == StAbort);
            comb_start_q  <= (state_d == StStartC);
            busy_q        <= !((state_d == StIdle) || (state_d == StDone) ||
                               (state_d == StError));
            done_q        <= (state_d == StDone);
            error_q       <= (state_d == StError);
        end
    end

    assign trans_clear_o = trans_clear_q;
    assign trans_start_o = trans_start_q;
    assign comb_clear_o  = comb_clear_q;
    assign comb_start_o  = comb_start_q;
    assign buf_sel_o     = layer_q[0];
    assign layer_idx_o   = layer_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_gcn_layer_scheduler.sv
// Bench for gcn_layer_scheduler: builds an expected per-cycle timeline from latency arithmetic,
// then replays it against the DUT, comparing every output each cycle.
module tb_gcn_layer_scheduler;

    localparam int NL   = 2;
    localparam int TO   = 16;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic go = 1'b0, ab = 1'b0, td = 1'b0, cd = 1'b0;
    logic tc, ts, cc, cs, bsel, busy, dn, er;
    logic [0:0] lidx;

    always #5 clk = ~clk;

    gcn_layer_scheduler #(
        .NUM_LAYERS    (NL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .go_i         (go),
        .abort_i      (ab),
        .trans_done_i (td),
        .comb_done_i  (cd),
        .trans_clear_o(tc),
        .trans_start_o(ts),
        .comb_clear_o (cc),
        .comb_start_o (cs),
        .buf_sel_o    (bsel),
        .layer_idx_o  (lidx),
        .busy_o       (busy),
        .done_o       (dn),
        .error_o      (er)
    );

    // {trans_clear, trans_start, comb_clear, comb_start, buf_sel, layer_idx, busy, done, error}
    logic [8:0] exp_v [MAXC];
    bit in_go [MAXC], in_ab [MAXC], in_td [MAXC], in_cd [MAXC], in_rst [MAXC];
    int t = 0;
    bit td_lvl = 0, cd_lvl = 0;
    logic [8:0] rest_v;
    int n_run, ev_at, ev_kind;   // ev_kind: 0 none, 1 abort, 2 abort+go, 3 reset
    bit ev_hit;
    int cur_l;
    int dt_a [NL], dc_a [NL];
    int tests = 0, fails = 0;
    logic [8:0] obs;

    function automatic logic [8:0] mk(bit ptc, bit pts, bit pcc, bit pcs, int layer,
                                      bit pbusy, bit pdn, bit per);
        bit lb;
        lb = layer[0];
        return {ptc, pts, pcc, pcs, lb, lb, pbusy, pdn, per};
    endfunction

    task automatic emit(input logic [8:0] v);
        exp_v[t]  = v;
        in_td[t]  = td_lvl;
        in_cd[t]  = cd_lvl;
        in_go[t]  = 0;
        in_ab[t]  = 0;
        in_rst[t] = 0;
        if (ev_kind != 0 && n_run == ev_at) begin
            ev_hit = 1;
            if (ev_kind == 1 || ev_kind == 2) in_ab[t] = 1;
            if (ev_kind == 2) in_go[t] = 1;
            if (ev_kind == 3) in_rst[t] = 1;
        end
        n_run++;
        t++;
    endtask

    task automatic step(input logic [8:0] v);
        int k;
        emit(v);
        if (ev_hit) begin
            k = ev_kind;
            ev_kind = 0;
            if (k != 3) begin
                emit(mk(1, 0, 1, 0, cur_l, 1, 0, 0));
                td_lvl = 0;
                cd_lvl = 0;
            end
            rest_v = mk(0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic fill_rest(input int n);
        for (int i = 0; i < n; i++) emit(rest_v);
    endtask

    // go in cycle 0; per layer: clrT, stT, dt-1 quiet waits, done-wait, clrC, stC, ..., NEXT.
    task automatic plan_run();
        logic [8:0] w;
        n_run  = 0;
        ev_hit = 0;
        emit(rest_v);
        in_go[t-1] = 1;
        for (int l = 0; l < NL; l++) begin
            cur_l = l;
            w = mk(0, 0, 0, 0, l, 1, 0, 0);
            step(mk(1, 0, 0, 0, l, 1, 0, 0)); if (ev_hit) return;
            td_lvl = 0;
            step(mk(0, 1, 0, 0, l, 1, 0, 0)); if (ev_hit) return;
            if (dt_a[l] > TO) begin
                for (int k = 0; k < TO; k++) begin step(w); if (ev_hit) return; end
                rest_v = mk(0, 0, 0, 0, l, 0, 0, 1);
                ev_kind = 0;
                return;
            end
            for (int k = 0; k < dt_a[l] - 1; k++) begin step(w); if (ev_hit) return; end
            td_lvl = 1;
            step(w); if (ev_hit) return;
            step(mk(0, 0, 1, 0, l, 1, 0, 0)); if (ev_hit) return;
            cd_lvl = 0;
            step(mk(0, 0, 0, 1, l, 1, 0, 0)); if (ev_hit) return;
            if (dc_a[l] > TO) begin
                for (int k = 0; k < TO; k++) begin step(w); if (ev_hit) return; end
                rest_v = mk(0, 0, 0, 0, l, 0, 0, 1);
                ev_kind = 0;
                return;
            end
            for (int k = 0; k < dc_a[l] - 1; k++) begin step(w); if (ev_hit) return; end
            cd_lvl = 1;
            step(w); if (ev_hit) return;
            step(w); if (ev_hit) return;
        end
        rest_v  = mk(0, 0, 0, 0, NL - 1, 0, 1, 0);
        ev_kind = 0;
    endtask

    task automatic set_lat(input int t0, input int c0, input int t1, input int c1);
        dt_a[0] = t0; dc_a[0] = c0; dt_a[1] = t1; dc_a[1] = c1;
    endtask

    initial begin
        rest_v  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        ev_kind = 0;

        // Idle with a stray abort (ignored).
        fill_rest(2);
        emit(rest_v); in_ab[t-1] = 1;
        fill_rest(2);
        // Nominal two-layer run, then rerun from DONE with the same latencies.
        set_lat(5, 8, 5, 8);
        plan_run(); fill_rest(3);
        plan_run(); fill_rest(3);
        // Transformation never finishes: watchdog to ERROR, then restart.
        set_lat(17, 8, 5, 8);
        plan_run(); fill_rest(3);
        set_lat(3, 4, 2, 6);
        plan_run(); fill_rest(2);
        // Done on the last watchdog cycle wins over the timeout.
        set_lat(16, 16, 16, 16);
        plan_run(); fill_rest(2);
        // Abort in WAIT_C of layer 1.
        set_lat(5, 8, 5, 8);
        ev_kind = 1; ev_at = 29;
        plan_run(); fill_rest(3);
        // go and abort together in WAIT_T.
        ev_kind = 2; ev_at = 4;
        plan_run(); fill_rest(3);
        // Abort while in DONE.
        plan_run(); fill_rest(2);
        emit(rest_v); in_ab[t-1] = 1;
        emit(mk(1, 0, 1, 0, NL - 1, 1, 0, 0));
        td_lvl = 0; cd_lvl = 0;
        rest_v = mk(0, 0, 0, 0, 0, 0, 0, 0);
        fill_rest(2);
        // Reset in WAIT_T with trans_done high; stale done must not move IDLE.
        ev_kind = 3; ev_at = 7;
        plan_run(); fill_rest(4);
        set_lat(2, 2, 2, 2);
        plan_run(); fill_rest(2);
        // Randomised latencies and events.
        for (int r = 0; r < 10; r++) begin
            set_lat($urandom_range(1, 18), $urandom_range(1, 18),
                    $urandom_range(1, 18), $urandom_range(1, 18));
            ev_kind = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            ev_at   = $urandom_range(1, 60);
            plan_run();
            fill_rest($urandom_range(1, 3));
        end

        // Reset state.
        #2;
        tests++;
        assert ({tc, ts, cc, cs, bsel, lidx, busy, dn, er} === 9'b0)
        else begin
            fails++;
            $error("FAIL reset_state obs=%b exp=%b", {tc, ts, cc, cs, bsel, lidx, busy, dn, er},
                   9'b0);
        end

        for (int c = 0; c < t; c++) begin
            @(negedge clk);
            obs = {tc, ts, cc, cs, bsel, lidx, busy, dn, er};
            tests++;
            assert (obs === exp_v[c])
            else begin
                fails++;
                $error("FAIL cycle_%0d obs=%b exp=%b", c, obs, exp_v[c]);
            end
            go = in_go[c];
            ab = in_ab[c];
            td = in_td[c];
            cd = in_cd[c];
            if (in_rst[c]) begin
                rst_n = 1'b0;
                #1;
                obs = {tc, ts, cc, cs, bsel, lidx, busy, dn, er};
                tests++;
                assert (obs === 9'b0)
                else begin
                    fails++;
                    $error("FAIL async_reset_%0d obs=%b exp=%b", c, obs, 9'b0);
                end
            end else begin
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
